// File: rtl/jkff_pkg.sv
// ---------------------------------------------------------------------------
// jkff_pkg
// Shared definitions for the JK flip-flop bank.
//   - JK_* op codes name the four {J,K} input combinations.
//   - jk_next() returns the next state of one JK bit given j, k and the
//     current q; it is the single place the JK truth table lives.
// ---------------------------------------------------------------------------
package jkff_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Next-state of a single JK bit. Unknown op codes (X/Z on j/k) fall
  // through to hold, so they cannot invent a new value on their own.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic [1:0] op;
    logic       nxt;
    op  = {j, k};
    nxt = q;
    case (op)
      JK_HOLD: nxt = q;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage : jkff_pkg

// File: rtl/jkff_block_bit.sv
// ---------------------------------------------------------------------------
// jkff_bit
// One JK flip-flop with synchronous active-high reset.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active high, priority over j/k
//   j    in   set/toggle request
//   k    in   clear/toggle request
//   q    out  registered state
// ---------------------------------------------------------------------------
module jkff_bit
  import jkff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = jk_next(j, k, q_q);
  end

  // Reset is tested first so that X/Z on j/k while rst=1 never reaches q_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : jkff_bit

// File: rtl/jkff_block.sv
// ---------------------------------------------------------------------------
// jkff_block
// Bank of WIDTH independent JK flip-flops sharing one clock and one
// synchronous reset.
// Parameters:
//   WIDTH    number of JK bits (>= 1)
//   RST_VAL  value loaded into every Q bit on reset
// Ports:
//   clk  in   [1]      rising-edge clock, every edge is an update
//   rst  in   [1]      synchronous reset, active high
//   J    in   [WIDTH]  per-bit set/toggle request
//   K    in   [WIDTH]  per-bit clear/toggle request
//   Q    out  [WIDTH]  registered state
//   Q_n  out  [WIDTH]  complement of Q, derived from Q only
// ---------------------------------------------------------------------------
module jkff_block
  import jkff_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_bit #(
      .RST_VAL (RST_VAL)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .j   (J[i]),
      .k   (K[i]),
      .q   (Q[i])
    );
  end

  // Q_n comes from the registered Q, so it has no path from J/K either.
  assign Q_n = ~Q;

endmodule : jkff_block

// File: tb/tb_jkff_block.sv
// ---------------------------------------------------------------------------
// tb_jkff_block
// Self-checking bench for jkff_block. Three instances run side by side:
//   dut1  WIDTH=1, RST_VAL=0  (classic single JK flip-flop)
//   dut4  WIDTH=4, RST_VAL=0
//   dut2  WIDTH=2, RST_VAL=1
// A vector-level reference model built from the JK characteristic
// equation predicts Q after every edge.
// ---------------------------------------------------------------------------
module tb_jkff_block;

  logic       clk;
  logic       rst;
  logic       j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;
  logic [1:0] j2, k2, q2, qn2;

  logic       m1;
  logic [3:0] m4;
  logic [1:0] m2;
  logic       modelValid;

  int compared;
  int mismatched;

  jkff_block #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk (clk), .rst (rst), .J (j1), .K (k1), .Q (q1), .Q_n (qn1)
  );

  jkff_block #(.WIDTH(4), .RST_VAL(1'b0)) dut4 (
    .clk (clk), .rst (rst), .J (j4), .K (k4), .Q (q4), .Q_n (qn4)
  );

  jkff_block #(.WIDTH(2), .RST_VAL(1'b1)) dut2 (
    .clk (clk), .rst (rst), .J (j2), .K (k2), .Q (q2), .Q_n (qn2)
  );

  // Period 20, first rising edge at t=10.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Characteristic equation Qn = (J & ~Q) | (~K & Q), applied to a whole vector.
  function automatic logic [3:0] modelNext(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, "_q1"},  {3'b000, q1},  {3'b000, m1});
    checkOutput({phase, "_qn1"}, {3'b000, qn1}, {3'b000, ~m1});
    checkOutput({phase, "_q4"},  q4,  m4);
    checkOutput({phase, "_qn4"}, qn4, ~m4);
    checkOutput({phase, "_q2"},  {2'b00, q2},  {2'b00, m2});
    checkOutput({phase, "_qn2"}, {2'b00, qn2}, {2'b00, ~m2});
  endtask

  // One clock of stimulus: confirm Q is still steady mid-cycle, drive new
  // inputs on the falling edge, advance the model on the rising edge and
  // sample the DUTs 1 time unit later.
  task automatic applyStimulus(input logic r, input logic j1v, input logic k1v,
                               input logic [3:0] j4v, input logic [3:0] k4v,
                               input logic [1:0] j2v, input logic [1:0] k2v);
    logic [3:0] t1;
    logic [3:0] t2;
    @(negedge clk);
    if (modelValid) begin
      checkOutput("stable_q1", {3'b000, q1}, {3'b000, m1});
      checkOutput("stable_q4", q4, m4);
    end
    rst = r;
    j1 = j1v; k1 = k1v;
    j4 = j4v; k4 = k4v;
    j2 = j2v; k2 = k2v;
    @(posedge clk);
    if (r) begin
      m1 = 1'b0;
      m4 = 4'b0000;
      m2 = 2'b11;
    end else begin
      t1 = modelNext({3'b000, m1}, {3'b000, j1v}, {3'b000, k1v});
      m1 = t1[0];
      m4 = modelNext(m4, j4v, k4v);
      t2 = modelNext({2'b00, m2}, {2'b00, j2v}, {2'b00, k2v});
      m2 = t2[1:0];
    end
    modelValid = 1'b1;
    #1;
    checkAll(r ? "reset" : "run");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    modelValid = 1'b0;
    m1 = 1'b0; m4 = '0; m2 = '0;

    // Reset with unknown J/K over the first edge (t=10).
    rst = 1'b1;
    j1 = 1'bx; k1 = 1'bx;
    j4 = 4'bxxxx; k4 = 4'bxxxx;
    j2 = 2'bxx; k2 = 2'bxx;
    @(posedge clk);
    m1 = 1'b0; m4 = 4'b0000; m2 = 2'b11;
    modelValid = 1'b1;
    #1;
    checkAll("por");
    checkOutput("por_q1_const", {3'b000, q1}, 4'b0000);
    checkOutput("por_q2_const", {2'b00, q2}, 4'b0011);

    // Single-bit directed walk: hold, clear, set, hold, four toggles.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b01, 2'b00);
    checkOutput("set_q1_const", {3'b000, q1}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2'b11, 2'b11);
    end
    checkOutput("tgl4_q1_const", {3'b000, q1}, 4'b0001);

    // Reset in the middle of toggling, then toggling resumes from RST_VAL.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 2'b11, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 2'b11, 2'b11);
    checkOutput("resume_q1_const", {3'b000, q1}, 4'b0001);

    // Multi-bit: start from 0000, mixed J/K, then toggle all bits.
    applyStimulus(1'b1, 1'bx, 1'bx, 4'hx, 4'hx, 2'bxx, 2'bxx);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010, 4'b0110, 2'b10, 2'b01);
    checkOutput("mix_q4_const", q4, 4'b1010);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 2'b00, 2'b00);
    checkOutput("tglall_q4_const", q4, 4'b0101);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    1'($urandom), 1'($urandom),
                    4'($urandom), 4'($urandom),
                    2'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_jkff_block
